rom_addr_sequencer: RTL and testbench
=====================================

# rom_addr_sequencer

Address-generation stage that drives the 4-bit address input of the seven-segment ROM in place of raw slide switches. It steps the address up or down, either automatically on a divided-clock tick or manually on a debounced pushbutton press, and supports a direct load from the switches. It emits a one-cycle strobe whenever the address value changes.

## Interface
- TICK_DIV, 50_000_000: clock cycles per auto-advance (1 Hz at 50 MHz); must be ≥ 2.
- DEBOUNCE_CYCLES, 1_000_000: cycles the synchronized button must stay stable before a level change is accepted (20 ms at 50 MHz); must be ≥ 2.
- clk  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- sw  input  4  load value.
- load  input  1  level; while high, `addr <= sw` every cycle.
- auto_en  input  1  1 = advance on the prescaler tick; 0 = advance on a debounced button press.
- dir  input  1  1 = count up, 0 = count down.
- step_btn  input  1  raw asynchronous pushbutton, active-high.
- addr  output  4  registered ROM address.
- addr_changed  output  1  registered strobe; high for exactly the one cycle in which `addr` first shows a new value.

## Operation
- **Synchronizer:** `step_btn` passes through a 2-flop synchronizer to give `btn_s`.
- **Debounce FSM:** one counter `cnt` (wide enough for DEBOUNCE_CYCLES-1) and four states.
  - IDLE_LOW: if `btn_s`=1, go to WAIT_HIGH and set `cnt`=0.
  - WAIT_HIGH:
    - If `btn_s`=0, go back to IDLE_LOW.
    - Else if `cnt`=DEBOUNCE_CYCLES-1, go to IDLE_HIGH. `press` (combinational) is high in this cycle only.
    - Else `cnt`+1.
  - IDLE_HIGH: if `btn_s`=0, go to WAIT_LOW and set `cnt`=0.
  - WAIT_LOW:
    - If `btn_s`=1, go back to IDLE_HIGH.
    - Else if `cnt`=DEBOUNCE_CYCLES-1, go to IDLE_LOW.
    - Else `cnt`+1.
  - Release generates no pulse.
  - The FSM runs regardless of `auto_en`. `press` is ignored when `auto_en`=1.
- **Prescaler:** `pcnt` counts 0..TICK_DIV-1 while `auto_en`=1 and `load`=0.
  - `tick` is high when `pcnt`=TICK_DIV-1; `pcnt` then wraps to 0.
  - `pcnt` is forced to 0 whenever `auto_en`=0 or `load`=1.
- **Address update, in priority order:**
  1. `load`=1: `addr <= sw`.
  2. `adv`=1: `addr <= addr±1` (modulo 16). `adv` = (`auto_en` ? `tick` : `press`).
  3. Otherwise hold.
- **Wrap:** up counting goes 15→0; down counting goes 0→15. Arithmetic is 4-bit and unsigned.
- **addr_changed:** registered as (next `addr` ≠ current `addr`).
  - Holding `load` with a constant `sw` produces one strobe at most.
  - Loading a value equal to `addr` produces none.
- **Reset (asynchronous, any time):**
  - `addr`=0, `addr_changed`=0, `pcnt`=0, `cnt`=0.
  - FSM goes to IDLE_LOW; synchronizer flops are cleared to 0.
  - If the button is held through reset release, it is debounced and counted as a new press.

## Timing
- Manual latency: with `step_btn` held high from sampling edge E0, `press` is high in the cycle after edge E0+DEBOUNCE_CYCLES+1. `addr` and `addr_changed` update at edge E0+DEBOUNCE_CYCLES+2.
- A high glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no press.
- Auto latency: the first advance occurs at the TICK_DIV-th rising edge after `auto_en` is first sampled high. Later advances occur every TICK_DIV cycles.
- Load latency: `addr` equals `sw` after one edge. `addr_changed` is coincident with the new value.
- Mode switch:
  - Falling `auto_en` discards partial prescaler progress.
  - A button already in IDLE_HIGH when switching to manual produces no step; a new press is required.
- Simultaneous `load` and `tick`/`press`: load wins, the advance is lost, and the prescaler restarts from 0.
- `dir` is sampled on the advancing edge only.

## Test plan
1. **Reset.** Set TICK_DIV=4 and DEBOUNCE_CYCLES=4. Assert `reset_n`=0 mid-count with `addr`=9. Required: `addr`=0 and `addr_changed`=0 immediately and without a clock; no advance until 4 cycles after release with `auto_en`=1.
2. **Auto up with wrap.** `auto_en`=1, `dir`=1, start at 14. Required: 15 at edge 4, 0 at edge 8, 1 at edge 12, `addr_changed` one cycle each. Then `dir`=0 from 1: sequence 0, 15.
3. **Manual debounce.**
   - Hold `step_btn` high from edge E0. Required: 0→1 at E0+6, exactly one step, `addr_changed` for one cycle.
   - A 3-cycle glitch gives no step.
   - Bounce 1-0-1 inside the window restarts the count.
   - Release followed by a re-press within 3 cycles gives no new step.
4. **Load priority.**
   - `load`=1, `sw`=4'hA on the same edge as a tick. Required: `addr`=A, one strobe, prescaler restarts at 0.
   - Hold `load` for 10 cycles. Required: no further strobes.
   - Load of the current value. Required: no strobe.
5. **Mode switch.**
   - Auto with `pcnt`=2, drop `auto_en`, raise it again. Required: next advance 4 edges after the rise.
   - Button held while entering manual. Required: no step until release and re-press.

Source files
------------

// File: rtl/rom_addr_sequencer.sv
// Address sequencer for the seven-segment ROM: direct load, auto-advance on a
// prescaler tick, or manual advance on a debounced pushbutton press.
module rom_addr_sequencer #(
    parameter int unsigned TICK_DIV        = 50_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] sw,
    input  logic       load,
    input  logic       auto_en,
    input  logic       dir,
    input  logic       step_btn,
    output logic [3:0] addr,
    output logic       addr_changed
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [PW-1:0] PCNT_MAX = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LOW,
        WAIT_HIGH,
        IDLE_HIGH,
        WAIT_LOW
    } db_state_e;

    db_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          btn_meta_q, btn_meta_d;
    logic          btn_s_q, btn_s_d;
    logic [3:0]    addr_q, addr_d;
    logic          addr_changed_q, addr_changed_d;
    logic          press;
    logic          tick;
    logic          adv;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE_LOW;
            cnt_q          <= '0;
            pcnt_q         <= '0;
            btn_meta_q     <= 1'b0;
            btn_s_q        <= 1'b0;
            addr_q         <= '0;
            addr_changed_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pcnt_q         <= pcnt_d;
            btn_meta_q     <= btn_meta_d;
            btn_s_q        <= btn_s_d;
            addr_q         <= addr_d;
            addr_changed_q <= addr_changed_d;
        end
    end

    always_comb begin
        btn_meta_d = step_btn;
        btn_s_d    = btn_meta_q;
    end

    // Debounce: a level is accepted only after DEBOUNCE_CYCLES stable samples;
    // only the accepted rising level produces a press.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press   = 1'b0;
        unique case (state_q)
            IDLE_LOW: begin
                if (btn_s_q) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!btn_s_q) begin
                    state_d = IDLE_LOW;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE_HIGH;
                    press   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE_HIGH: begin
                if (!btn_s_q) begin
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (btn_s_q) begin
                    state_d = IDLE_HIGH;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE_LOW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE_LOW;
        endcase
    end

    always_comb begin
        tick = (pcnt_q == PCNT_MAX);
        if (!auto_en || load || tick) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + 1'b1;
        end
    end

    always_comb begin
        adv = auto_en ? tick : press;
        if (load) begin
            addr_d = sw;
        end else if (adv) begin
            addr_d = dir ? addr_q + 4'd1 : addr_q - 4'd1;
        end else begin
            addr_d = addr_q;
        end
        addr_changed_d = (addr_d != addr_q);
    end

    assign addr         = addr_q;
    assign addr_changed = addr_changed_q;

endmodule

// File: tb/tb_rom_addr_sequencer.sv
// Scoreboard bench for rom_addr_sequencer: each expected address change is
// queued with the edge it must appear on and matched against addr_changed.
module tb_rom_addr_sequencer;

    logic       clk;
    logic       reset_n;
    logic [3:0] sw;
    logic       load;
    logic       auto_en;
    logic       dir;
    logic       step_btn;
    logic [3:0] addr;
    logic       addr_changed;

    typedef struct {
        logic [3:0]  a;
        int unsigned e;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned ecnt;
    int unsigned total;
    int unsigned bad;

    rom_addr_sequencer #(
        .TICK_DIV       (4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sw          (sw),
        .load        (load),
        .auto_en     (auto_en),
        .dir         (dir),
        .step_btn    (step_btn),
        .addr        (addr),
        .addr_changed(addr_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic check_val(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d (edge %0d)", tag, got, want, ecnt);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input logic [3:0] a, input int unsigned e);
        exp_t x;
        x.a = a;
        x.e = e;
        exp_q.push_back(x);
    endtask

    // Monitor: strobes are matched in order; an expectation whose edge has
    // passed without a strobe is reported as missed.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].e < ecnt) begin
            check_val("missed_change", int'(ecnt), int'(exp_q[0].e));
            void'(exp_q.pop_front());
        end
        if (addr_changed) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_strobe", int'(addr_changed), 0);
            end else begin
                check_val("strobe_edge", int'(ecnt), int'(exp_q[0].e));
                check_val("strobe_addr", int'(addr), int'(exp_q[0].a));
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int unsigned b;
        total    = 0;
        bad      = 0;
        reset_n  = 1'b0;
        sw       = 4'd0;
        load     = 1'b0;
        auto_en  = 1'b0;
        dir      = 1'b1;
        step_btn = 1'b0;
        #1;
        check_val("reset_addr", int'(addr), 0);
        check_val("reset_changed", int'(addr_changed), 0);
        step(2);
        reset_n = 1'b1;
        step(1);

        // Reset mid-count with addr=9, auto still enabled across release
        load = 1'b1; sw = 4'd9;
        expect_at(4'd9, ecnt + 1);
        step(1);
        load = 1'b0; auto_en = 1'b1;
        step(2);
        #2 reset_n = 1'b0;
        #1;
        check_val("async_reset_addr", int'(addr), 0);
        check_val("async_reset_changed", int'(addr_changed), 0);
        step(2);
        reset_n = 1'b1;
        expect_at(4'd1, ecnt + 4);
        step(4);
        auto_en = 1'b0;

        // Auto up with wrap, then down across 0
        load = 1'b1; sw = 4'd14;
        expect_at(4'd14, ecnt + 1);
        step(1);
        load = 1'b0; auto_en = 1'b1;
        b = ecnt;
        expect_at(4'd15, b + 4);
        expect_at(4'd0,  b + 8);
        expect_at(4'd1,  b + 12);
        step(12);
        dir = 1'b0;
        expect_at(4'd0,  b + 16);
        expect_at(4'd15, b + 20);
        step(8);
        auto_en = 1'b0; dir = 1'b1;
        step(2);
        check_val("auto_down_addr", int'(addr), 15);

        // Manual: clean press
        load = 1'b1; sw = 4'd0;
        expect_at(4'd0, ecnt + 1);
        step(1);
        load = 1'b0;
        step(2);
        step_btn = 1'b1;
        expect_at(4'd1, ecnt + 7);
        step(20);
        check_val("manual_one_step", int'(addr), 1);
        step_btn = 1'b0;
        step(10);

        // Short glitch: no step
        step_btn = 1'b1;
        step(3);
        step_btn = 1'b0;
        step(10);
        check_val("glitch_no_step", int'(addr), 1);

        // Bounce 1-0-1 restarts the window
        step_btn = 1'b1;
        step(2);
        step_btn = 1'b0;
        step(1);
        step_btn = 1'b1;
        expect_at(4'd2, ecnt + 7);
        step(20);
        // Short release then re-press: no new step
        step_btn = 1'b0;
        step(2);
        step_btn = 1'b1;
        step(12);
        step_btn = 1'b0;
        step(10);
        check_val("repress_no_step", int'(addr), 2);

        // Load coincident with tick, held load, then restart of prescaler
        auto_en = 1'b1;
        step(3);
        load = 1'b1; sw = 4'hA;
        expect_at(4'hA, ecnt + 1);
        step(10);
        load = 1'b0;
        expect_at(4'hB, ecnt + 4);
        step(4);
        auto_en = 1'b0;
        check_val("load_then_adv", int'(addr), 11);
        load = 1'b1; sw = 4'hB;
        step(2);
        load = 1'b0;
        step(2);
        check_val("load_same_value", int'(addr), 11);

        // Falling auto_en discards prescaler progress
        auto_en = 1'b1;
        step(2);
        auto_en = 1'b0;
        step(1);
        auto_en = 1'b1;
        expect_at(4'hC, ecnt + 4);
        step(4);
        auto_en = 1'b0;

        // Button debounced while in auto, then switch to manual: no step
        auto_en = 1'b1; step_btn = 1'b1;
        expect_at(4'hD, ecnt + 4);
        step(7);
        auto_en = 1'b0;
        step(10);
        check_val("held_into_manual", int'(addr), 13);
        step_btn = 1'b0;
        step(10);
        step_btn = 1'b1;
        expect_at(4'hE, ecnt + 7);
        step(12);
        step_btn = 1'b0;
        step(10);
        check_val("repress_after_switch", int'(addr), 14);

        check_val("pending_expectations", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
